// File: rtl/ex_alu_branch_stage.sv
// Registered EX stage: ALU result, zero flag, branch decision and target held in an
// EX/MEM output register with a valid/ready handshake, plus a saturating taken-branch counter.
module ex_alu_branch_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [1:0]       branchcontrol,
  input  logic             is_branch,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_target,
  output logic             illegal_op,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_branch_taken;
  logic [WIDTH-1:0] r_branch_target;
  logic             r_illegal_op;
  logic [CNT_W-1:0] r_taken_count;

  logic             w_capture;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_taken;
  logic             w_lt;
  logic             w_cnt_sat;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_cnt_sat = (r_taken_count == {CNT_W{1'b1}});

  // ALU datapath
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (operation)
      OP_AND:  w_result = op_a & op_b;
      OP_OR:   w_result = op_a | op_b;
      OP_ADD:  w_result = op_a + op_b;
      OP_SUB:  w_result = op_a - op_b;
      default: w_illegal = 1'b1;
    endcase
  end

  // Branch decision uses a true signed compare, independent of the ALU operation
  always_comb begin
    w_lt    = $signed(op_a) < $signed(op_b);
    w_taken = 1'b0;
    if (is_branch) begin
      case (branchcontrol)
        2'b00:   w_taken = (op_a == op_b);
        2'b01:   w_taken = (op_a != op_b);
        2'b10:   w_taken = w_lt;
        default: w_taken = !w_lt;
      endcase
    end
  end

  // EX/MEM output register; flush beats capture and hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid     <= 1'b0;
      r_result        <= '0;
      r_zero          <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_illegal_op    <= 1'b0;
      r_taken_count   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid     <= 1'b1;
      r_result        <= w_result;
      r_zero          <= (w_result == '0);
      r_branch_taken  <= w_taken;
      r_branch_target <= pc + imm;
      r_illegal_op    <= w_illegal;
      if (w_taken && !w_cnt_sat) begin
        r_taken_count <= r_taken_count + CNT_W'(1);
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign result        = r_result;
  assign zero          = r_zero;
  assign branch_taken  = r_branch_taken;
  assign branch_target = r_branch_target;
  assign illegal_op    = r_illegal_op;
  assign taken_count   = r_taken_count;

endmodule
